// File: rtl/instruction_timing_sequencer.sv
// Per-instruction cycle sequencer: walks FETCH -> ADDR -> OP and drives the cycle index
// and phase flags consumed by the control-flag decoder.
module instruction_timing_sequencer #(
   parameter int TIME_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready,
   input  logic [TIME_W-1:0] addressTimingCode,
   input  logic [TIME_W-1:0] opTimingCode,
   input  logic              passAddressing,
   input  logic              pageCross,
   output logic [TIME_W-1:0] timeOut,
   output logic              isAddressing,
   output logic              isFetch,
   output logic              instructionDone
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ADDR  = 2'd1,
      S_OP    = 2'd2
   } state_t;

   state_t            r_state;
   logic [TIME_W-1:0] r_time;
   logic [TIME_W-1:0] r_addr_cnt;
   logic [TIME_W-1:0] r_op_cnt;
   logic              r_bypass;
   logic              r_pc_used;

   state_t            w_state;
   logic [TIME_W-1:0] w_time;
   logic [TIME_W-1:0] w_addr_cnt;
   logic [TIME_W-1:0] w_op_cnt;
   logic              w_bypass;
   logic              w_pc_used;
   logic [TIME_W-1:0] w_addr_last;
   logic [TIME_W-1:0] w_op_last;

   // Once the page-cross cycle has been inserted, the last ADDR index moves up by one.
   assign w_addr_last = r_pc_used ? r_addr_cnt : (r_addr_cnt - TIME_W'(1));
   // An op count of zero still takes one OP cycle.
   assign w_op_last   = (r_op_cnt == '0) ? '0 : (r_op_cnt - TIME_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_time     <= '0;
         r_addr_cnt <= '0;
         r_op_cnt   <= '0;
         r_bypass   <= 1'b0;
         r_pc_used  <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_time     <= w_time;
         r_addr_cnt <= w_addr_cnt;
         r_op_cnt   <= w_op_cnt;
         r_bypass   <= w_bypass;
         r_pc_used  <= w_pc_used;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_time     = r_time;
      w_addr_cnt = r_addr_cnt;
      w_op_cnt   = r_op_cnt;
      w_bypass   = r_bypass;
      w_pc_used  = r_pc_used;
      if (ready) begin
         case (r_state)
            S_FETCH: begin
               w_addr_cnt = addressTimingCode;
               w_op_cnt   = opTimingCode;
               w_bypass   = passAddressing;
               w_pc_used  = 1'b0;
               w_time     = '0;
               w_state    = (!passAddressing && (addressTimingCode != '0)) ? S_ADDR : S_OP;
            end
            S_ADDR: begin
               if (r_time == w_addr_last) begin
                  if (pageCross && !r_pc_used) begin
                     w_pc_used = 1'b1;
                     w_time    = r_time + TIME_W'(1);
                  end else begin
                     w_state = S_OP;
                     w_time  = '0;
                  end
               end else begin
                  w_time = r_time + TIME_W'(1);
               end
            end
            S_OP: begin
               if (r_time == w_op_last) begin
                  w_state = S_FETCH;
                  w_time  = '0;
               end else begin
                  w_time = r_time + TIME_W'(1);
               end
            end
            default: begin
               w_state = S_FETCH;
               w_time  = '0;
            end
         endcase
      end
   end

   assign timeOut         = r_time;
   assign isFetch         = (r_state == S_FETCH);
   assign isAddressing    = (r_state == S_ADDR) && !r_bypass;
   assign instructionDone = (r_state == S_OP) && (r_time == w_op_last);

endmodule

// File: tb/tb_instruction_timing_sequencer.sv
// Directed bench for instruction_timing_sequencer: hand-computed cycle-by-cycle expectations.
module tb_instruction_timing_sequencer;

   localparam int TIME_W = 3;

   logic              clk;
   logic              rst;
   logic              ready;
   logic [TIME_W-1:0] addressTimingCode;
   logic [TIME_W-1:0] opTimingCode;
   logic              passAddressing;
   logic              pageCross;
   logic [TIME_W-1:0] timeOut;
   logic              isAddressing;
   logic              isFetch;
   logic              instructionDone;

   int n_cmp = 0;
   int n_err = 0;

   instruction_timing_sequencer #(.TIME_W(TIME_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .ready             (ready),
      .addressTimingCode (addressTimingCode),
      .opTimingCode      (opTimingCode),
      .passAddressing    (passAddressing),
      .pageCross         (pageCross),
      .timeOut           (timeOut),
      .isAddressing      (isAddressing),
      .isFetch           (isFetch),
      .instructionDone   (instructionDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TIME_W-1:0] et,
                      input logic ea, input logic ef, input logic ed);
      logic [TIME_W+2:0] obs;
      logic [TIME_W+2:0] exp;
      obs = {timeOut, isAddressing, isFetch, instructionDone};
      exp = {et, ea, ef, ed};
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed t=%0d addr=%0b fetch=%0b done=%0b, expected t=%0d addr=%0b fetch=%0b done=%0b",
                tag, obs[TIME_W+2:3], obs[2], obs[1], obs[0], et, ea, ef, ed);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_codes(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] o,
                            input logic pa, input logic pc);
      addressTimingCode = a;
      opTimingCode      = o;
      passAddressing    = pa;
      pageCross         = pc;
   endtask

   initial begin
      rst = 1'b1;
      ready = 1'b1;
      set_codes(3'd0, 3'd0, 1'b0, 1'b0);
      #1;
      chk("reset", 3'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      chk("post_reset_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Full sequence: addr=2 op=3
      set_codes(3'd2, 3'd3, 1'b0, 1'b0);
      step(); chk("full_addr_t0", 3'd0, 1'b1, 1'b0, 1'b0);
      set_codes(3'd5, 3'd1, 1'b1, 1'b1);  // ignored outside FETCH; pageCross off at last ADDR below
      step(); chk("full_addr_t1", 3'd1, 1'b1, 1'b0, 1'b0);
      pageCross = 1'b0;
      step(); chk("full_op_t0", 3'd0, 1'b0, 1'b0, 1'b0);
      step(); chk("full_op_t1", 3'd1, 1'b0, 1'b0, 1'b0);
      step(); chk("full_op_t2", 3'd2, 1'b0, 1'b0, 1'b1);
      set_codes(3'd3, 3'd2, 1'b1, 1'b0);
      step(); chk("full_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Bypass: addr=3 ignored, op=2
      step(); chk("byp_op_t0", 3'd0, 1'b0, 1'b0, 1'b0);
      step(); chk("byp_op_t1", 3'd1, 1'b0, 1'b0, 1'b1);
      set_codes(3'd2, 3'd1, 1'b0, 1'b1);
      step(); chk("byp_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Page cross held: addr=2 op=1 -> one extra ADDR cycle only
      step(); chk("pc_addr_t0", 3'd0, 1'b1, 1'b0, 1'b0);
      step(); chk("pc_addr_t1", 3'd1, 1'b1, 1'b0, 1'b0);
      step(); chk("pc_addr_t2", 3'd2, 1'b1, 1'b0, 1'b0);
      step(); chk("pc_op_t0", 3'd0, 1'b0, 1'b0, 1'b1);
      set_codes(3'd7, 3'd1, 1'b0, 1'b1);
      step(); chk("pc_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // addr=7 with page cross reaches timeOut=7 without wrap
      for (int i = 0; i < 8; i++) begin
         step(); chk($sformatf("pc7_addr_t%0d", i), TIME_W'(i), 1'b1, 1'b0, 1'b0);
      end
      step(); chk("pc7_op_t0", 3'd0, 1'b0, 1'b0, 1'b1);
      set_codes(3'd1, 3'd2, 1'b0, 1'b0);
      step(); chk("pc7_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Stall: addr=1 op=2, 3 stalls in ADDR t0, 2 stalls in OP t1
      step(); chk("stl_addr_t0", 3'd0, 1'b1, 1'b0, 1'b0);
      ready = 1'b0;
      opTimingCode = 3'd6;
      for (int i = 0; i < 3; i++) begin
         step(); chk($sformatf("stl_addr_hold%0d", i), 3'd0, 1'b1, 1'b0, 1'b0);
      end
      ready = 1'b1;
      step(); chk("stl_op_t0", 3'd0, 1'b0, 1'b0, 1'b0);
      step(); chk("stl_op_t1", 3'd1, 1'b0, 1'b0, 1'b1);
      ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step(); chk($sformatf("stl_op_hold%0d", i), 3'd1, 1'b0, 1'b0, 1'b1);
      end
      ready = 1'b1;
      set_codes(3'd1, 3'd1, 1'b0, 1'b0);
      step(); chk("stl_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Stall in FETCH holds; then stall with pageCross in last ADDR, re-sampled when ready returns
      ready = 1'b0;
      step(); chk("fetch_hold", 3'd0, 1'b0, 1'b1, 1'b0);
      ready = 1'b1;
      step(); chk("spc_addr_t0", 3'd0, 1'b1, 1'b0, 1'b0);
      ready = 1'b0;
      pageCross = 1'b1;
      step(); chk("spc_addr_hold", 3'd0, 1'b1, 1'b0, 1'b0);
      ready = 1'b1;
      step(); chk("spc_addr_t1", 3'd1, 1'b1, 1'b0, 1'b0);
      step(); chk("spc_op_t0", 3'd0, 1'b0, 1'b0, 1'b1);
      set_codes(3'd3, 3'd0, 1'b1, 1'b0);
      step(); chk("spc_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      // Zero op count with bypass -> single OP cycle; code changes mid-OP ignored
      step(); chk("z_op_t0", 3'd0, 1'b0, 1'b0, 1'b1);
      set_codes(3'd2, 3'd3, 1'b0, 1'b0);
      step(); chk("z_fetch", 3'd0, 1'b0, 1'b1, 1'b0);
      step(); chk("z_next_addr_t0", 3'd0, 1'b1, 1'b0, 1'b0);
      step(); chk("z_next_addr_t1", 3'd1, 1'b1, 1'b0, 1'b0);
      step(); chk("z_next_op_t0", 3'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-OP, between edges
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", 3'd0, 1'b0, 1'b1, 1'b0);
      step(); chk("reset_held", 3'd0, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      set_codes(3'd0, 3'd2, 1'b0, 1'b0);
      step(); chk("rel_op_t0", 3'd0, 1'b0, 1'b0, 1'b0);
      step(); chk("rel_op_t1", 3'd1, 1'b0, 1'b0, 1'b1);
      step(); chk("rel_fetch", 3'd0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
